// File: rtl/rs_gf_pkg.sv
// GF(2^8) constants, helpers and FSM encodings shared by the RS decoder stages.
package rs_gf_pkg;

    localparam logic [8:0] GF_POLY      = 9'h11D;
    localparam logic [7:0] GF_ALPHA     = 8'h02;
    localparam logic [7:0] GF_ALPHA_INV = 8'h8E;

    // One-hot Chien/Forney control states
    typedef enum logic [3:0] {
        ST_IDLE = 4'b0001,
        ST_LOAD = 4'b0010,
        ST_RUN  = 4'b0100,
        ST_DONE = 4'b1000
    } chien_state_t;

    // Multiply by alpha: shift left and fold the x^8 term back in
    function automatic logic [7:0] gf_mul_alpha(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? GF_POLY[7:0] : 8'h00);
    endfunction

    // General product, shift-and-add over the field
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] sh;
        acc = 8'h00;
        sh  = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc ^= sh;
            sh = gf_mul_alpha(sh);
        end
        return acc;
    endfunction

    // Multiply by alpha^-1; the constant operand folds to a fixed XOR network
    function automatic logic [7:0] gf_mul_alpha_inv(input logic [7:0] a);
        return gf_mul(a, GF_ALPHA_INV);
    endfunction

    // alpha^k for elaboration-time constants; k is reduced modulo 255
    function automatic logic [7:0] gf_alpha_pow(input int k);
        logic [7:0] r;
        int         e;
        e = k % 255;
        if (e < 0) e += 255;
        r = 8'h01;
        for (int i = 0; i < e; i++) r = gf_mul(r, GF_ALPHA);
        return r;
    endfunction

endpackage

// File: rtl/s3_chien_forney_if.sv
// Handoff from the key-equation solver and the Chien/Forney result stream.
interface s3_chien_forney_if;

    logic       kes_done;
    logic [7:0] rs_lambda0;
    logic [7:0] rs_lambda1;
    logic [7:0] rs_lambda2;
    logic [7:0] rs_omega0;
    logic [7:0] rs_omega1;

    logic       out_valid;
    logic [7:0] out_pos;
    logic [7:0] out_err;
    logic       out_last;
    logic       chien_done;
    logic [1:0] err_num;
    logic       dec_fail;
    logic       chien_ovf;

    modport master (
        output kes_done, rs_lambda0, rs_lambda1, rs_lambda2, rs_omega0, rs_omega1,
        input  out_valid, out_pos, out_err, out_last, chien_done, err_num, dec_fail, chien_ovf
    );

    modport slave (
        input  kes_done, rs_lambda0, rs_lambda1, rs_lambda2, rs_omega0, rs_omega1,
        output out_valid, out_pos, out_err, out_last, chien_done, err_num, dec_fail, chien_ovf
    );

endinterface

// File: rtl/gf2m8_inv.sv
// Combinational GF(2^8) inverse; zero maps to zero.
module gf2m8_inv
    import rs_gf_pkg::*;
(
    input  logic [7:0] a,
    output logic [7:0] a_inv
);

    logic [7:0] pw;
    logic [7:0] prod;

    // a^-1 = a^254 = a^2 * a^4 * ... * a^128, so a zero input yields zero
    always_comb begin
        pw   = a;
        prod = 8'h01;
        for (int k = 1; k < 8; k++) begin
            pw   = gf_mul(pw, pw);
            prod = gf_mul(prod, pw);
        end
        a_inv = prod;
    end

endmodule

// File: rtl/gf2m8_multi.sv
// Combinational GF(2^8) multiplier.
module gf2m8_multi
    import rs_gf_pkg::*;
(
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic [7:0] p
);

    // Field product of the two operands
    always_comb p = gf_mul(a, b);

endmodule

// File: rtl/s3_chien_forney.sv
// RS decoder stage 3: Chien root search over all positions, highest first,
// with one Forney magnitude streamed per position (t = 2, first root alpha^0).
module s3_chien_forney
    import rs_gf_pkg::*;
#(
    parameter int N = 255
) (
    input  logic             clk,
    input  logic             rst,
    s3_chien_forney_if.slave bus
);

    localparam logic [7:0] CNT_INIT = 8'(N - 1);
    localparam logic [7:0] X_INIT   = gf_alpha_pow(N - 1);
    localparam logic [7:0] T1_SCALE = gf_alpha_pow(255 - (N - 1));
    localparam logic [7:0] T2_SCALE = gf_alpha_pow(510 - 2 * (N - 1));

    chien_state_t state, nxt_state;

    logic [7:0] lam0, lam1, lam2, om0, om1;
    logic [7:0] t1, t2, x_pos, inv_l1, cnt;
    logic [1:0] deg, roots;

    logic [7:0] t1_load, t2_load, inv_w, om0_x, mag_raw, mag;
    logic       run, is_root, dec_fail_w;

    logic       vld_p1, last_p1, done_p1, ovf_p1, dec_fail_p1;
    logic [7:0] pos_p1, err_p1;
    logic [1:0] err_num_p1;

    // Root counter saturates so err_num never wraps
    function automatic logic [1:0] sat_inc(input logic [1:0] v);
        return (v == 2'd3) ? v : v + 2'd1;
    endfunction

    gf2m8_multi u_t1_load (.a(lam1),          .b(T1_SCALE), .p(t1_load));
    gf2m8_multi u_t2_load (.a(lam2),          .b(T2_SCALE), .p(t2_load));
    gf2m8_multi u_om0_x   (.a(om0),           .b(x_pos),    .p(om0_x));
    gf2m8_multi u_mag     (.a(om0_x ^ om1),   .b(inv_l1),   .p(mag_raw));
    gf2m8_inv   u_inv     (.a(lam1),          .a_inv(inv_w));

    assign run        = (state == ST_RUN);
    assign is_root    = ((lam0 ^ t1 ^ t2) == 8'h00);
    // Lambda'(x) = lambda1 in characteristic 2; no derivative means no magnitude
    assign mag        = (is_root && (lam1 != 8'h00)) ? mag_raw : 8'h00;
    assign dec_fail_w = (lam0 == 8'h00) | ((lam1 == 8'h00) & (deg != 2'd0)) | (roots != deg);

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= nxt_state;
    end

    // Next-state: one LOAD cycle, N RUN cycles, one DONE cycle
    always_comb begin
        nxt_state = state;
        unique case (state)
            ST_IDLE: if (bus.kes_done) nxt_state = ST_LOAD;
            ST_LOAD: nxt_state = ST_RUN;
            ST_RUN:  if (cnt == 8'h00) nxt_state = ST_DONE;
            ST_DONE: nxt_state = ST_IDLE;
            default: nxt_state = ST_IDLE;
        endcase
    end

    // Coefficient capture, LOAD initialisation and per-position Chien stepping
    always_ff @(posedge clk) begin
        if ((state == ST_IDLE) && bus.kes_done) begin
            lam0 <= bus.rs_lambda0;
            lam1 <= bus.rs_lambda1;
            lam2 <= bus.rs_lambda2;
            om0  <= bus.rs_omega0;
            om1  <= bus.rs_omega1;
        end
        if (state == ST_LOAD) begin
            t1     <= t1_load;
            t2     <= t2_load;
            x_pos  <= X_INIT;
            inv_l1 <= inv_w;
            cnt    <= CNT_INIT;
            deg    <= (lam2 != 8'h00) ? 2'd2 : ((lam1 != 8'h00) ? 2'd1 : 2'd0);
            roots  <= 2'd0;
        end else if (run) begin
            t1    <= gf_mul_alpha(t1);
            t2    <= gf_mul_alpha(gf_mul_alpha(t2));
            x_pos <= gf_mul_alpha_inv(x_pos);
            cnt   <= cnt - 8'd1;
            if (is_root) roots <= sat_inc(roots);
        end
    end

    // ---- output stage p1: registered beat stream, status and overrun pulses ----
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1      <= 1'b0;
            pos_p1      <= 8'h00;
            err_p1      <= 8'h00;
            last_p1     <= 1'b0;
            done_p1     <= 1'b0;
            ovf_p1      <= 1'b0;
            err_num_p1  <= 2'd0;
            dec_fail_p1 <= 1'b0;
        end else begin
            vld_p1  <= run;
            pos_p1  <= run ? cnt : 8'h00;
            err_p1  <= run ? mag : 8'h00;
            last_p1 <= run && (cnt == 8'h00);
            done_p1 <= (state == ST_DONE);
            ovf_p1  <= bus.kes_done && (state != ST_IDLE);
            if (state == ST_DONE) begin
                err_num_p1  <= roots;
                dec_fail_p1 <= dec_fail_w;
            end
        end
    end

    assign bus.out_valid  = vld_p1;
    assign bus.out_pos    = pos_p1;
    assign bus.out_err    = err_p1;
    assign bus.out_last   = last_p1;
    assign bus.chien_done = done_p1;
    assign bus.err_num    = err_num_p1;
    assign bus.dec_fail   = dec_fail_p1;
    assign bus.chien_ovf  = ovf_p1;

endmodule
